// File: rtl/encin_phase_dec_if.sv
// Register/pin bundle between the pin mux, the APB register block and encin_phase_dec.
// master = register block / pin side, slave = decoder.
interface encin_phase_dec_if #(
  parameter int FILT_W = 4
);
  logic              i_reg_ence;
  logic              i_reg_pol;
  logic              i_reg_zclr;
  logic [FILT_W-1:0] i_reg_filt;
  logic [15:0]       i_reg_posmax;
  logic              i_wr_poscnt;
  logic [15:0]       i_wdata;
  logic              i_err_clr;
  logic              i_pina;
  logic              i_pinb;
  logic              i_pinz;
  logic [15:0]       o_reg_poscnt;
  logic [15:0]       o_reg_zcap;
  logic              o_dir;
  logic              o_cnt_pulse;
  logic              o_wrap;
  logic              o_zdet;
  logic              o_phase_err;
  logic              o_err_sticky;

  modport master (
    output i_reg_ence, i_reg_pol, i_reg_zclr, i_reg_filt, i_reg_posmax,
           i_wr_poscnt, i_wdata, i_err_clr, i_pina, i_pinb, i_pinz,
    input  o_reg_poscnt, o_reg_zcap, o_dir, o_cnt_pulse, o_wrap, o_zdet,
           o_phase_err, o_err_sticky
  );

  modport slave (
    input  i_reg_ence, i_reg_pol, i_reg_zclr, i_reg_filt, i_reg_posmax,
           i_wr_poscnt, i_wdata, i_err_clr, i_pina, i_pinb, i_pinz,
    output o_reg_poscnt, o_reg_zcap, o_dir, o_cnt_pulse, o_wrap, o_zdet,
           o_phase_err, o_err_sticky
  );
endinterface

// File: rtl/encin_phase_dec.sv
// Quadrature encoder input decoder: per-pin sync + stability filter, x4 decode into a
// wrapping position counter, direction, Z index capture/clear and phase-error reporting.
module encin_phase_dec #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input logic              i_pclk,
  input logic              i_presetn,
  encin_phase_dec_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  logic [2:0] pin_raw;
  logic [2:0] pin_filt;

  assign pin_raw = {bus.i_pinz, bus.i_pinb, bus.i_pina};

  // Bit 0 = A, 1 = B, 2 = Z. The run counter saturates so any filt value stays reachable.
  for (genvar gi = 0; gi < 3; gi++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q, last_d;
    logic                   filt_q, filt_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
      last_d = synced;
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (synced != last_q) begin
        cnt_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
      if ((synced != filt_q) && (cnt_d >= bus.i_reg_filt)) begin
        filt_d = synced;
      end
    end

    always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
        sync_q <= '0;
        last_q <= 1'b0;
        filt_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        sync_q <= sync_d;
        last_q <= last_d;
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign pin_filt[gi] = filt_q;
  end

  state_t      state_q, state_d;
  logic [1:0]  prev_idx_q, prev_idx_d;
  logic        z_prev_q, z_prev_d;
  logic [15:0] poscnt_q, poscnt_d;
  logic [15:0] zcap_q, zcap_d;
  logic        dir_q, dir_d;
  logic        cnt_pulse_q, cnt_pulse_d;
  logic        wrap_q, wrap_d;
  logic        zdet_q, zdet_d;
  logic        perr_q, perr_d;
  logic        sticky_q, sticky_d;

  logic [1:0]  idx;
  logic [1:0]  delta;
  logic [15:0] posmax_m1;
  logic        z_rise;
  logic        cnt_up;

  assign posmax_m1 = bus.i_reg_posmax - 16'd1;
  assign z_rise    = pin_filt[2] & ~z_prev_q;
  assign delta     = idx - prev_idx_q;

  // Phase order matches the generator: {A,B} 10,00,01,11 -> 0,1,2,3.
  always_comb begin
    idx = 2'd3;
    unique case ({pin_filt[0], pin_filt[1]})
      2'b10:   idx = 2'd0;
      2'b00:   idx = 2'd1;
      2'b01:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prev_idx_d  = prev_idx_q;
    z_prev_d    = pin_filt[2];
    poscnt_d    = poscnt_q;
    zcap_d      = zcap_q;
    dir_d       = dir_q;
    cnt_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    zdet_d      = 1'b0;
    perr_d      = 1'b0;
    cnt_up      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_wr_poscnt) begin
          poscnt_d = bus.i_wdata;
        end
        state_d = ST_ARM;
      end
      ST_ARM: begin
        prev_idx_d = idx;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        prev_idx_d = idx;
        if ((delta == 2'd1) || (delta == 2'd3)) begin
          cnt_up      = (delta == 2'd1) ^ bus.i_reg_pol;
          cnt_pulse_d = 1'b1;
          dir_d       = ~cnt_up;
          // Equality-only wrap: a position above a freshly lowered modulus keeps counting.
          if (cnt_up) begin
            if (poscnt_q == posmax_m1) begin
              poscnt_d = 16'd0;
              wrap_d   = 1'b1;
            end else begin
              poscnt_d = poscnt_q + 16'd1;
            end
          end else begin
            if (poscnt_q == 16'd0) begin
              poscnt_d = posmax_m1;
              wrap_d   = 1'b1;
            end else begin
              poscnt_d = poscnt_q - 16'd1;
            end
          end
        end else if (delta == 2'd2) begin
          perr_d = 1'b1;
        end
        if (z_rise) begin
          zdet_d = 1'b1;
          zcap_d = poscnt_q;
          if (bus.i_reg_zclr) begin
            poscnt_d = 16'd0;
            wrap_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.i_reg_ence) begin
      state_d = ST_IDLE;
    end

    // A new error in the clearing cycle keeps the flag set.
    sticky_d = perr_d | (sticky_q & ~bus.i_err_clr);
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      state_q     <= ST_IDLE;
      prev_idx_q  <= 2'd0;
      z_prev_q    <= 1'b0;
      poscnt_q    <= 16'd0;
      zcap_q      <= 16'd0;
      dir_q       <= 1'b0;
      cnt_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      zdet_q      <= 1'b0;
      perr_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_idx_q  <= prev_idx_d;
      z_prev_q    <= z_prev_d;
      poscnt_q    <= poscnt_d;
      zcap_q      <= zcap_d;
      dir_q       <= dir_d;
      cnt_pulse_q <= cnt_pulse_d;
      wrap_q      <= wrap_d;
      zdet_q      <= zdet_d;
      perr_q      <= perr_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.o_reg_poscnt = poscnt_q;
  assign bus.o_reg_zcap   = zcap_q;
  assign bus.o_dir        = dir_q;
  assign bus.o_cnt_pulse  = cnt_pulse_q;
  assign bus.o_wrap       = wrap_q;
  assign bus.o_zdet       = zdet_q;
  assign bus.o_phase_err  = perr_q;
  assign bus.o_err_sticky = sticky_q;

endmodule

// File: tb/tb_encin_phase_dec.sv
// Bench for encin_phase_dec: directed scenarios with literal expectations, then random
// pin/register traffic checked every cycle against a pin-history reference model.
module tb_encin_phase_dec;
  localparam int S  = 2;
  localparam int FW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encin_phase_dec_if #(.FILT_W(FW)) bus ();

  encin_phase_dec #(.SYNC_STAGES(S), .FILT_W(FW)) dut (
    .i_pclk    (clk),
    .i_presetn (rst_n),
    .bus       (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int cnt_pulses = 0, cnt_wraps = 0, cnt_zdets = 0, cnt_perrs = 0;

  // Reference model: raw pin history, filtered levels, decoder mode (0 idle, 1 arm, 2 run)
  logic [2:0]  hist [64];
  int          edge_n;
  int          m_mode;
  int          m_prev;
  logic        m_fa, m_fb, m_fz, m_fz_old;
  logic [15:0] m_pos, m_zcap;
  logic        m_dir, m_cnt, m_wrap, m_zdet, m_perr, m_sticky;

  function automatic int phase_of(input logic a, input logic b);
    case ({a, b})
      2'b10:   return 0;
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) hist[i] = 3'b000;
    edge_n = 100;
    m_mode = 0; m_prev = 0;
    m_fa = 0; m_fb = 0; m_fz = 0; m_fz_old = 0;
    m_pos = 0; m_zcap = 0;
    m_dir = 0; m_cnt = 0; m_wrap = 0; m_zdet = 0; m_perr = 0; m_sticky = 0;
  endtask

  task automatic model_step();
    int          idx, delta, ft;
    bit          up, zrise, stable;
    logic        v;
    logic [15:0] pm1, old_pos;
    idx     = phase_of(m_fa, m_fb);
    zrise   = m_fz && !m_fz_old;
    m_fz_old = m_fz;
    old_pos = m_pos;
    pm1     = bus.i_reg_posmax - 16'd1;
    m_cnt = 0; m_wrap = 0; m_zdet = 0; m_perr = 0;
    if (m_mode == 0) begin
      if (bus.i_wr_poscnt) m_pos = bus.i_wdata;
    end else if (m_mode == 1) begin
      m_prev = idx;
    end else begin
      delta  = (idx - m_prev + 4) % 4;
      m_prev = idx;
      if (delta == 1 || delta == 3) begin
        up    = (delta == 1) ^ bus.i_reg_pol;
        m_cnt = 1;
        m_dir = !up;
        if (up) begin
          if (m_pos == pm1) begin m_pos = 0; m_wrap = 1; end
          else m_pos = m_pos + 16'd1;
        end else begin
          if (m_pos == 0) begin m_pos = pm1; m_wrap = 1; end
          else m_pos = m_pos - 16'd1;
        end
      end else if (delta == 2) begin
        m_perr = 1;
      end
      if (zrise) begin
        m_zdet = 1;
        m_zcap = old_pos;
        if (bus.i_reg_zclr) begin m_pos = 0; m_wrap = 0; end
      end
    end
    if (m_perr) m_sticky = 1;
    else if (bus.i_err_clr) m_sticky = 0;
    if (!bus.i_reg_ence) m_mode = 0;
    else if (m_mode < 2) m_mode = m_mode + 1;
    // A filtered level follows a synchronized value once it has held for filt+1 samples
    edge_n++;
    hist[edge_n % 64] = {bus.i_pinz, bus.i_pinb, bus.i_pina};
    ft = int'(bus.i_reg_filt);
    for (int p = 0; p < 3; p++) begin
      v = hist[(edge_n - S) % 64][p];
      stable = 1;
      for (int k = 1; k <= ft; k++)
        if (hist[(edge_n - S - k) % 64][p] != v) stable = 0;
      if (stable) begin
        if (p == 0) m_fa = v;
        else if (p == 1) m_fb = v;
        else m_fz = v;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (bus.o_reg_poscnt !== m_pos || bus.o_reg_zcap !== m_zcap ||
          {bus.o_dir, bus.o_cnt_pulse, bus.o_wrap, bus.o_zdet, bus.o_phase_err, bus.o_err_sticky}
          !== {m_dir, m_cnt, m_wrap, m_zdet, m_perr, m_sticky}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t poscnt=%h exp %h zcap=%h exp %h dir/cnt/wrap/zdet/perr/sticky=%b exp %b",
                 $time, bus.o_reg_poscnt, m_pos, bus.o_reg_zcap, m_zcap,
                 {bus.o_dir, bus.o_cnt_pulse, bus.o_wrap, bus.o_zdet, bus.o_phase_err, bus.o_err_sticky},
                 {m_dir, m_cnt, m_wrap, m_zdet, m_perr, m_sticky});
      end
      if (bus.o_cnt_pulse) cnt_pulses++;
      if (bus.o_wrap)      cnt_wraps++;
      if (bus.o_zdet)      cnt_zdets++;
      if (bus.o_phase_err) cnt_perrs++;
    end
  end

  task automatic check_lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
    $display("check %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic a, input logic b);
    bus.i_pina = a;
    bus.i_pinb = b;
  endtask

  task automatic set_idx(input int i);
    case (i)
      0:       set_ab(1'b1, 1'b0);
      1:       set_ab(1'b0, 1'b0);
      2:       set_ab(1'b0, 1'b1);
      default: set_ab(1'b1, 1'b1);
    endcase
  endtask

  task automatic idle_load(input logic [15:0] val);
    bus.i_reg_ence = 1'b0;
    tick(2);
    bus.i_wr_poscnt = 1'b1;
    bus.i_wdata     = val;
    tick(1);
    bus.i_wr_poscnt = 1'b0;
  endtask

  initial begin
    int p0, w0, z0, e0, gidx, r;
    bus.i_reg_ence = 0; bus.i_reg_pol = 0; bus.i_reg_zclr = 0; bus.i_reg_filt = '0;
    bus.i_reg_posmax = 16'd8; bus.i_wr_poscnt = 0; bus.i_wdata = 16'd0; bus.i_err_clr = 0;
    bus.i_pina = 1; bus.i_pinb = 0; bus.i_pinz = 0;
    tick(3);
    check_lit("reset_poscnt", bus.o_reg_poscnt, 16'd0);
    check_lit("reset_zcap", bus.o_reg_zcap, 16'd0);
    check_lit("reset_flags", 16'({bus.o_dir, bus.o_cnt_pulse, bus.o_wrap, bus.o_zdet,
                                  bus.o_phase_err, bus.o_err_sticky}), 16'd0);
    rst_n = 1'b1;
    tick(6);
    bus.i_reg_ence = 1'b1;
    tick(4);

    // filt=0, posmax=8: four up steps, latency SYNC+0+2
    p0 = cnt_pulses; w0 = cnt_wraps;
    set_ab(0, 0); tick(3);
    check_lit("latency_before", bus.o_reg_poscnt, 16'd0);
    tick(1);
    check_lit("latency_after", bus.o_reg_poscnt, 16'd1);
    tick(4);
    set_ab(0, 1); tick(6); check_lit("up_step2", bus.o_reg_poscnt, 16'd2);
    set_ab(1, 1); tick(6); check_lit("up_step3", bus.o_reg_poscnt, 16'd3);
    set_ab(1, 0); tick(6); check_lit("up_step4", bus.o_reg_poscnt, 16'd4);
    check_lit("model_up4", m_pos, 16'd4);
    check_lit("up_dir", 16'(bus.o_dir), 16'd0);
    check_lit("up_pulses", 16'(cnt_pulses - p0), 16'd4);
    check_lit("up_wraps", 16'(cnt_wraps - w0), 16'd0);

    // pol=1: same sequence counts down through the wrap
    idle_load(16'd0);
    bus.i_reg_pol = 1'b1; bus.i_reg_ence = 1'b1;
    tick(4);
    w0 = cnt_wraps;
    set_ab(0, 0); tick(6); check_lit("dn_step1", bus.o_reg_poscnt, 16'd7);
    check_lit("dn_wrap_first", 16'(cnt_wraps - w0), 16'd1);
    set_ab(0, 1); tick(6); check_lit("dn_step2", bus.o_reg_poscnt, 16'd6);
    set_ab(1, 1); tick(6); check_lit("dn_step3", bus.o_reg_poscnt, 16'd5);
    set_ab(1, 0); tick(6); check_lit("dn_step4", bus.o_reg_poscnt, 16'd4);
    check_lit("dn_dir", 16'(bus.o_dir), 16'd1);
    check_lit("dn_wraps", 16'(cnt_wraps - w0), 16'd1);

    // Illegal jump 10 -> 01
    e0 = cnt_perrs;
    set_ab(0, 1); tick(6);
    check_lit("perr_pos_hold", bus.o_reg_poscnt, 16'd4);
    check_lit("perr_sticky", 16'(bus.o_err_sticky), 16'd1);
    check_lit("perr_pulses", 16'(cnt_perrs - e0), 16'd1);
    bus.i_err_clr = 1'b1; tick(1); bus.i_err_clr = 1'b0; tick(1);
    check_lit("perr_cleared", 16'(bus.o_err_sticky), 16'd0);

    // filt=3: 3-cycle glitch rejected, 6-cycle pulse counts at SYNC+5
    bus.i_reg_filt = FW'(3);
    tick(2);
    p0 = cnt_pulses;
    bus.i_pina = 1'b1; tick(3); bus.i_pina = 1'b0; tick(12);
    check_lit("glitch_pos", bus.o_reg_poscnt, 16'd4);
    check_lit("glitch_pulses", 16'(cnt_pulses - p0), 16'd0);
    bus.i_pina = 1'b1; tick(6);
    check_lit("filt_pre", bus.o_reg_poscnt, 16'd4);
    bus.i_pina = 1'b0; tick(1);
    check_lit("filt_edge", bus.o_reg_poscnt, 16'd3);
    check_lit("filt_one_count", 16'(cnt_pulses - p0), 16'd1);
    tick(12);
    check_lit("filt_return", bus.o_reg_poscnt, 16'd4);

    // zclr with Z rising together with an up edge
    idle_load(16'd5);
    bus.i_reg_pol = 1'b0; bus.i_reg_filt = '0; bus.i_reg_zclr = 1'b1; bus.i_reg_ence = 1'b1;
    tick(4);
    p0 = cnt_pulses; w0 = cnt_wraps; z0 = cnt_zdets;
    bus.i_pina = 1'b1; bus.i_pinz = 1'b1; tick(6);
    check_lit("zclr_zcap", bus.o_reg_zcap, 16'd5);
    check_lit("zclr_pos", bus.o_reg_poscnt, 16'd0);
    check_lit("zclr_zdet", 16'(cnt_zdets - z0), 16'd1);
    check_lit("zclr_nowrap", 16'(cnt_wraps - w0), 16'd0);
    check_lit("zclr_pulse", 16'(cnt_pulses - p0), 16'd1);
    bus.i_pinz = 1'b0; bus.i_reg_zclr = 1'b0; tick(6);

    // posmax=0: natural 16-bit wrap, then register write only honoured in IDLE
    idle_load(16'hFFFF);
    bus.i_reg_posmax = 16'd0; bus.i_reg_ence = 1'b1;
    tick(4);
    w0 = cnt_wraps;
    set_ab(1, 0); tick(6);
    check_lit("pm0_pos", bus.o_reg_poscnt, 16'h0000);
    check_lit("pm0_wrap", 16'(cnt_wraps - w0), 16'd1);
    idle_load(16'h1234); tick(1);
    check_lit("wr_idle", bus.o_reg_poscnt, 16'h1234);
    bus.i_reg_ence = 1'b1; tick(4);
    bus.i_wr_poscnt = 1'b1; bus.i_wdata = 16'h5555; tick(1);
    bus.i_wr_poscnt = 1'b0; tick(2);
    check_lit("wr_run_ignored", bus.o_reg_poscnt, 16'h1234);

    // Randomized traffic, one async reset in the middle
    gidx = 0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 15) gidx = (gidx + 1) % 4;
      else if (r < 30) gidx = (gidx + 3) % 4;
      else if (r < 32) gidx = (gidx + 2) % 4;
      set_idx(gidx);
      if ($urandom_range(0, 99) < 4) bus.i_pinz = ~bus.i_pinz;
      bus.i_wr_poscnt = ($urandom_range(0, 99) < 5);
      bus.i_wdata     = 16'($urandom);
      bus.i_err_clr   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) bus.i_reg_pol  = ~bus.i_reg_pol;
      if ($urandom_range(0, 199) == 0) bus.i_reg_zclr = ~bus.i_reg_zclr;
      if (bus.i_reg_ence) begin
        if ($urandom_range(0, 99) == 0) bus.i_reg_ence = 1'b0;
      end else if ($urandom_range(0, 99) < 20) begin
        bus.i_reg_ence = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 4))
          0:       bus.i_reg_posmax = 16'd0;
          1:       bus.i_reg_posmax = 16'd8;
          2:       bus.i_reg_posmax = 16'd5;
          3:       bus.i_reg_posmax = 16'd300;
          default: bus.i_reg_posmax = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 299) == 0) bus.i_reg_filt = FW'($urandom_range(0, 3));
      if (c == 2000) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_lit("async_rst_pos", bus.o_reg_poscnt, 16'd0);
        check_lit("async_rst_sticky", 16'(bus.o_err_sticky), 16'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
      tick(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
